add_arbiter: RTL and testbench
==============================

# add_arbiter

Sequencer and arbiter that shares the single 3-bit `Add` unit between two requesters, A and B. Each requester presents two 3-bit operands with a level request. The block grants one requester at a time, drives the shared `Add` instance from latched operands, and registers the 4-bit sum and zero flag. It returns a one-cycle acknowledge to the granted requester. It sits between the control logic and the `Add` datapath, and is the only driver of `Add` inputs.

## Interface
Parameters:
- `FIXED_PRIORITY`, default 0 — 0: round-robin arbitration; 1: A always wins a tie.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_a`  in  1  requester A operation request (level)
- `num1_a`, `num2_a`  in  3 each  requester A operands
- `req_b`  in  1  requester B operation request (level)
- `num1_b`, `num2_b`  in  3 each  requester B operands
- `ack_a`  out  1  one-cycle pulse: A's result valid on `result`/`zeroflag`
- `ack_b`  out  1  one-cycle pulse: B's result valid on `result`/`zeroflag`
- `result`  out  4  registered sum of granted operands
- `zeroflag`  out  1  registered; 1 iff `result` == 0
- `grant`  out  1  owner of current/last operation (0 = A, 1 = B)
- `busy`  out  1  high in ISSUE and DONE

## Operation
- Internal `Add` instance; its `num1`/`num2` inputs are driven only from the internal operand registers.
- FSM states: IDLE, ISSUE, DONE.
  - IDLE: if `req_a` or `req_b` is sampled high, select a winner, latch its operands, set `grant`, go to ISSUE; else stay.
  - ISSUE: capture the `Add` outputs into `result`/`zeroflag`; go to DONE.
  - DONE: pulse the winner's ack; update the priority pointer; go to IDLE.
- Arbitration, `FIXED_PRIORITY` = 0: on a tie, the requester not served last wins. A single requester wins regardless of the pointer. The pointer resets to "B served last", so A wins the first tie.
- Arbitration, `FIXED_PRIORITY` = 1: on a tie, A always wins. The pointer is ignored.
- Arithmetic: `result` = {0,num1} + {0,num2}, unsigned, range 0..14, no overflow possible. `zeroflag` is set only for 0+0.
- Operands are latched at the grant edge. Later operand or `req` changes do not affect the in-flight operation.
- Requester rule: hold `req` until ack. Drive `req` low in the cycle after ack unless it intends a new operation. `req` still high in the IDLE cycle after ack counts as a new request.
- A `req` that drops before grant is not served, and no ack is issued.
- `result`, `zeroflag` and `grant` hold their last values between operations.

## Timing
- Reset values: state IDLE, `ack_a`=0, `ack_b`=0, `result`=0000, `zeroflag`=0, `grant`=0, `busy`=0, pointer = B.
- Latency: `req` sampled at edge E0 (IDLE). ISSUE begins at E0, DONE begins at E1. Ack and valid `result` are high for exactly the cycle between E1 and E2.
- Throughput: one operation per 3 cycles. Back-to-back requests from both sides alternate A, B, A, B under round-robin.
- `result`/`zeroflag` update at E1 and are stable while the ack is high.
- `ack_a` and `ack_b` are never high together, and never high outside DONE.
- Reset mid-operation: `rst` high at any edge forces the reset values next cycle. No ack is issued for the aborted operation. Requests still pending after `rst` falls are re-arbitrated from IDLE with the pointer at B.
- A request arriving during ISSUE/DONE waits; it is considered at the first IDLE edge.

## Test plan
- Reset: assert `rst` 2 cycles → all outputs at reset values, `busy`=0.
- Single A: `req_a`=1, `num1_a`=101, `num2_a`=011 → 2 edges later `ack_a`=1 for 1 cycle, `result`=1000, `zeroflag`=0, `grant`=0, `ack_b`=0.
- Zero and maximum: B 000+000 → `result`=0000, `zeroflag`=1; then B 111+111 → `result`=1110, `zeroflag`=0.
- Contention, `FIXED_PRIORITY`=0: both requests held continuously after reset, A=001+001, B=010+010 → acks A,B,A,B every 3 cycles, with `result` 0010 and 0100 alternating. Same stimulus with `FIXED_PRIORITY`=1 → only `ack_a` pulses.
- Operand stability: A granted with 011+001, operands changed to 111+111 in ISSUE → `result`=0100.
- Reset mid-operation: `rst` pulsed during ISSUE of an A request held high → no `ack_a` for the aborted operation; after `rst` falls, `ack_a` arrives 3 cycles later with the correct sum.

Source files
------------

// File: rtl/add_arbiter_if.sv
// add_arbiter requester/result bundle.
// master = requester side, slave = arbiter side.
interface add_arbiter_if;
    logic       req_a;
    logic [2:0] num1_a;
    logic [2:0] num2_a;
    logic       req_b;
    logic [2:0] num1_b;
    logic [2:0] num2_b;
    logic       ack_a;
    logic       ack_b;
    logic [3:0] result;
    logic       zeroflag;
    logic       grant;
    logic       busy;

    modport master (
        output req_a, num1_a, num2_a,
        output req_b, num1_b, num2_b,
        input  ack_a, ack_b, result, zeroflag, grant, busy
    );

    modport slave (
        input  req_a, num1_a, num2_a,
        input  req_b, num1_b, num2_b,
        output ack_a, ack_b, result, zeroflag, grant, busy
    );
endinterface

// File: rtl/add_arbiter.sv
// Two-requester arbiter sharing one 3-bit adder.
// IDLE -> ISSUE -> DONE, one operation every 3 cycles.
module Add (
    input  logic [2:0] num1,
    input  logic [2:0] num2,
    output logic [3:0] sum,
    output logic       zero
);
    assign sum  = {1'b0, num1} + {1'b0, num2};
    assign zero = (sum == 4'd0);
endmodule

module add_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    add_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] op1_q, op1_d;
    logic [2:0] op2_q, op2_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic [3:0] result_q, result_d;
    logic       zf_q, zf_d;
    logic       ack_a_q, ack_a_d;
    logic       ack_b_q, ack_b_d;

    logic       any_req;
    logic       tie;
    logic       win_b;
    logic [3:0] add_sum;
    logic       add_zero;

    // Shared adder only ever sees the latched operands.
    Add u_add (
        .num1 (op1_q),
        .num2 (op2_q),
        .sum  (add_sum),
        .zero (add_zero)
    );

    // Winner select: last_q=1 means B was served last.
    always_comb begin
        any_req = bus.req_a | bus.req_b;
        tie     = bus.req_a & bus.req_b;
        if (FIXED_PRIORITY) begin
            win_b = bus.req_b & ~bus.req_a;
        end else if (tie) begin
            win_b = ~last_q;
        end else begin
            win_b = bus.req_b;
        end
    end

    // Next-state, operand latch, result capture and ack.
    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        grant_d  = grant_q;
        last_d   = last_q;
        result_d = result_q;
        zf_d     = zf_q;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = win_b;
                    op1_d   = win_b ? bus.num1_b : bus.num1_a;
                    op2_d   = win_b ? bus.num2_b : bus.num2_a;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                result_d = add_sum;
                zf_d     = add_zero;
                ack_a_d  = ~grant_q;
                ack_b_d  = grant_q;
                state_d  = DONE;
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op1_q    <= 3'd0;
            op2_q    <= 3'd0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            result_q <= 4'd0;
            zf_q     <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            result_q <= result_d;
            zf_q     <= zf_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
        end
    end

    assign bus.ack_a    = ack_a_q;
    assign bus.ack_b    = ack_b_q;
    assign bus.result   = result_q;
    assign bus.zeroflag = zf_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = (state_q != IDLE);

    // Acks are exclusive and confined to DONE.
    a_ack_excl: assert property (
        @(posedge clk) !(ack_a_q && ack_b_q)
    );
    a_ack_done: assert property (
        @(posedge clk) (ack_a_q || ack_b_q) |-> (state_q == DONE)
    );
endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: round-robin and fixed-priority
// instances on shared stimulus, checked against a timeline model.
module tb_add_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       ra, rb;
    logic [2:0] a1, a2, b1, b2;

    add_arbiter_if bus0 ();
    add_arbiter_if bus1 ();

    assign bus0.req_a = ra;
    assign bus0.num1_a = a1;
    assign bus0.num2_a = a2;
    assign bus0.req_b = rb;
    assign bus0.num1_b = b1;
    assign bus0.num2_b = b2;
    assign bus1.req_a = ra;
    assign bus1.num1_a = a1;
    assign bus1.num2_a = a2;
    assign bus1.req_b = rb;
    assign bus1.num1_b = b1;
    assign bus1.num2_b = b2;

    add_arbiter #(.FIXED_PRIORITY(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );
    add_arbiter #(.FIXED_PRIORITY(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int checks = 0;
    int errors = 0;

    // Timeline model: an op granted at edge g shows its ack/result
    // after edge g+1, and the next grant may happen at edge g+3.
    int         cyc = 0;
    int         m_free[2];
    int         m_ack_edge[2];
    bit         m_last[2];
    bit         m_gnt[2];
    bit         m_zf[2];
    logic [3:0] m_res[2];
    logic [3:0] m_sum[2];
    int         n_ack_a[2];
    int         n_ack_b[2];

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit win;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_free[k]     = cyc + 1;
                m_ack_edge[k] = -1;
                m_last[k]     = 1'b1;
                m_gnt[k]      = 1'b0;
                m_zf[k]       = 1'b0;
                m_res[k]      = 4'd0;
            end else begin
                if (m_ack_edge[k] == cyc) begin
                    m_res[k] = m_sum[k];
                    m_zf[k]  = (m_sum[k] == 4'd0);
                end
                if (cyc >= m_free[k] && (ra || rb)) begin
                    if (ra && rb)
                        win = (k == 1) ? 1'b0 : ~m_last[k];
                    else
                        win = rb;
                    m_last[k]     = win;
                    m_gnt[k]      = win;
                    m_sum[k]      = win ? (4'(b1) + 4'(b2))
                                        : (4'(a1) + 4'(a2));
                    m_ack_edge[k] = cyc + 1;
                    m_free[k]     = cyc + 3;
                end
            end
        end
    endtask

    task automatic step();
        logic ack_a, ack_b, zf, gnt, bsy;
        logic [3:0] res;
        bit   ea, eb;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                ack_a = bus0.ack_a; ack_b = bus0.ack_b;
                res = bus0.result; zf = bus0.zeroflag;
                gnt = bus0.grant; bsy = bus0.busy;
            end else begin
                ack_a = bus1.ack_a; ack_b = bus1.ack_b;
                res = bus1.result; zf = bus1.zeroflag;
                gnt = bus1.grant; bsy = bus1.busy;
            end
            ea = (m_ack_edge[k] == cyc) && !m_gnt[k];
            eb = (m_ack_edge[k] == cyc) && m_gnt[k];
            n_ack_a[k] += int'(ack_a);
            n_ack_b[k] += int'(ack_b);
            check($sformatf("d%0d_c%0d_ack_a", k, cyc), ack_a, ea);
            check($sformatf("d%0d_c%0d_ack_b", k, cyc), ack_b, eb);
            check($sformatf("d%0d_c%0d_result", k, cyc), res, m_res[k]);
            check($sformatf("d%0d_c%0d_zf", k, cyc), zf, m_zf[k]);
            check($sformatf("d%0d_c%0d_grant", k, cyc), gnt, m_gnt[k]);
            check($sformatf("d%0d_c%0d_busy", k, cyc), bsy,
                  int'(cyc < m_free[k] - 1));
        end
    endtask

    task automatic clr_counts();
        for (int k = 0; k < 2; k++) begin
            n_ack_a[k] = 0;
            n_ack_b[k] = 0;
        end
    endtask

    initial begin
        rst = 1'b1;
        ra = 1'b0; rb = 1'b0;
        a1 = 3'd0; a2 = 3'd0; b1 = 3'd0; b2 = 3'd0;
        clr_counts();

        // reset
        repeat (2) step();
        check("rst_result", bus0.result, 0);
        check("rst_busy", bus0.busy, 0);
        rst = 1'b0;
        step();

        // single A: 5 + 3
        ra = 1'b1; a1 = 3'd5; a2 = 3'd3;
        repeat (2) step();
        check("single_ack_a", bus0.ack_a, 1);
        check("single_result", bus0.result, 8);
        check("single_ack_b", bus0.ack_b, 0);
        ra = 1'b0;
        repeat (2) step();

        // B zero then B max back-to-back
        rb = 1'b1; b1 = 3'd0; b2 = 3'd0;
        repeat (2) step();
        check("zero_result", bus0.result, 0);
        check("zero_zf", bus0.zeroflag, 1);
        b1 = 3'd7; b2 = 3'd7;
        repeat (3) step();
        check("max_result", bus0.result, 14);
        check("max_zf", bus0.zeroflag, 0);
        rb = 1'b0;
        repeat (2) step();

        // contention from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        ra = 1'b1; rb = 1'b1;
        a1 = 3'd1; a2 = 3'd1; b1 = 3'd2; b2 = 3'd2;
        clr_counts();
        repeat (12) step();
        check("rr_acks_a", n_ack_a[0], 2);
        check("rr_acks_b", n_ack_b[0], 2);
        check("fp_acks_a", n_ack_a[1], 4);
        check("fp_acks_b", n_ack_b[1], 0);
        ra = 1'b0; rb = 1'b0;
        repeat (3) step();

        // operand stability
        ra = 1'b1; a1 = 3'd3; a2 = 3'd1;
        step();
        a1 = 3'd7; a2 = 3'd7;
        step();
        check("stable_result", bus0.result, 4);
        check("stable_ack_a", bus0.ack_a, 1);
        ra = 1'b0;
        repeat (2) step();

        // reset mid-operation
        ra = 1'b1; a1 = 3'd2; a2 = 3'd5;
        clr_counts();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_no_ack", n_ack_a[0], 0);
        repeat (2) step();
        check("abort_ack_a", bus0.ack_a, 1);
        check("abort_result", bus0.result, 7);
        ra = 1'b0;
        repeat (2) step();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            ra  = ($urandom_range(0, 3) != 0);
            rb  = ($urandom_range(0, 3) != 0);
            a1  = 3'($urandom);
            a2  = 3'($urandom);
            b1  = 3'($urandom);
            b2  = 3'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
